// File: rtl/lanes_mosi_dispatch.sv
// lanes_mosi_dispatch: frames the host MOSI byte stream into {dest, len-1, payload} packets and routes each to a lane.
// Optional feature macro MOSI_BROADCAST_EN: dest 0xFF fans a packet out to every enabled lane.
module lanes_mosi_dispatch #(
    parameter int LAYER_COUNT = 3
) (
    input  logic                     clk_core,
    input  logic                     clk_core_resn,
    input  logic [7:0]               host_s_axis_tdata,
    input  logic                     host_s_axis_tvalid,
    output logic                     host_s_axis_tready,
    output logic [8*LAYER_COUNT-1:0] lanes_mosi_m_axis_tdata,
    output logic [LAYER_COUNT-1:0]   lanes_mosi_m_axis_tvalid,
    output logic [LAYER_COUNT-1:0]   lanes_mosi_m_axis_tlast,
    input  logic [LAYER_COUNT-1:0]   lanes_mosi_m_axis_tready,
    input  logic [LAYER_COUNT-1:0]   config_lanes_disable_mosi,
    input  logic                     config_dispatch_flush,
    output logic                     status_busy,
    output logic [7:0]               status_dest,
    output logic [31:0]              stat_packets,
    output logic [15:0]              stat_drops
);
    // state | meaning
    // HDR   | waiting for destination byte
    // LEN   | waiting for length byte, destination resolved here
    // PAY   | payload passthrough to target lane(s)
    // DROP  | payload consumed and discarded
    typedef enum logic [1:0] {ST_HDR, ST_LEN, ST_PAY, ST_DROP} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             dest_q, dest_d;
    logic [8:0]             rem_q, rem_d;
    logic [LAYER_COUNT-1:0] target_q, target_d;
    logic [LAYER_COUNT-1:0] acc_q, acc_d;
    logic [31:0]            pkts_q, pkts_d;
    logic [15:0]            drops_q, drops_d;

    logic                   host_acc;
    logic [LAYER_COUNT-1:0] route;
    logic [LAYER_COUNT-1:0] lane_valid;

    always_comb begin
        route = '0;
        for (int i = 0; i < LAYER_COUNT; i++) begin
            if (dest_q == 8'(i + 1)) route[i] = 1'b1;
        end
        route = route & ~config_lanes_disable_mosi;
`ifdef MOSI_BROADCAST_EN
        if (dest_q == 8'hFF) route = ~config_lanes_disable_mosi;
`endif
    end

    // Flush and reset both block the host side and mask every lane immediately.
    always_comb begin
        lane_valid         = '0;
        host_s_axis_tready = 1'b0;
        if (clk_core_resn && !config_dispatch_flush) begin
            case (state_q)
                ST_PAY: begin
                    lane_valid         = {LAYER_COUNT{host_s_axis_tvalid}} & target_q & ~acc_q;
                    host_s_axis_tready = &(acc_q | lanes_mosi_m_axis_tready | ~target_q);
                end
                default: host_s_axis_tready = 1'b1;
            endcase
        end
    end

    assign host_acc                 = host_s_axis_tvalid & host_s_axis_tready;
    assign lanes_mosi_m_axis_tdata  = {LAYER_COUNT{host_s_axis_tdata}};
    assign lanes_mosi_m_axis_tvalid = lane_valid;
    assign lanes_mosi_m_axis_tlast  = lane_valid & {LAYER_COUNT{rem_q == 9'd1}};
    assign status_busy              = (state_q != ST_HDR);
    assign status_dest              = dest_q;
    assign stat_packets             = pkts_q;
    assign stat_drops               = drops_q;

    always_comb begin
        state_d  = state_q;
        dest_d   = dest_q;
        rem_d    = rem_q;
        target_d = target_q;
        acc_d    = acc_q;
        pkts_d   = pkts_q;
        drops_d  = drops_q;
        case (state_q)
            ST_HDR: begin
                if (host_acc) begin
                    dest_d  = host_s_axis_tdata;
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (host_acc) begin
                    rem_d    = {1'b0, host_s_axis_tdata} + 9'd1;
                    target_d = route;
                    acc_d    = '0;
                    state_d  = (|route) ? ST_PAY : ST_DROP;
                end
            end
            ST_PAY: begin
`ifdef MOSI_BROADCAST_EN
                acc_d = acc_q | (lane_valid & lanes_mosi_m_axis_tready);
`endif
                if (host_acc) begin
                    acc_d = '0;
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        pkts_d   = pkts_q + 32'd1;
                        target_d = '0;
                        state_d  = ST_HDR;
                    end
                end
            end
            ST_DROP: begin
                if (host_acc) begin
                    rem_d = rem_q - 9'd1;
                    if (rem_q == 9'd1) begin
                        if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
                        state_d = ST_HDR;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase
        // host_acc is already 0 under flush, so counters cannot move here.
        if (config_dispatch_flush) begin
            state_d  = ST_HDR;
            target_d = '0;
            acc_d    = '0;
        end
    end

    always_ff @(posedge clk_core) begin
        if (!clk_core_resn) begin
            state_q  <= ST_HDR;
            dest_q   <= '0;
            rem_q    <= '0;
            target_q <= '0;
            acc_q    <= '0;
            pkts_q   <= '0;
            drops_q  <= '0;
        end else begin
            state_q  <= state_d;
            dest_q   <= dest_d;
            rem_q    <= rem_d;
            target_q <= target_d;
            acc_q    <= acc_d;
            pkts_q   <= pkts_d;
            drops_q  <= drops_d;
        end
    end

endmodule

// File: tb/tb_lanes_mosi_dispatch.sv
// Bench for lanes_mosi_dispatch: packet-level reference model fed by directed and randomized traffic.
module tb_lanes_mosi_dispatch;
    localparam int LC = 3;

    logic            clk_core = 1'b0;
    logic            clk_core_resn = 1'b0;
    logic [7:0]      host_s_axis_tdata = '0;
    logic            host_s_axis_tvalid = 1'b0;
    logic            host_s_axis_tready;
    logic [8*LC-1:0] lanes_mosi_m_axis_tdata;
    logic [LC-1:0]   lanes_mosi_m_axis_tvalid;
    logic [LC-1:0]   lanes_mosi_m_axis_tlast;
    logic [LC-1:0]   lane_ready = '1;
    logic [LC-1:0]   dis = '0;
    logic            config_dispatch_flush = 1'b0;
    logic            status_busy;
    logic [7:0]      status_dest;
    logic [31:0]     stat_packets;
    logic [15:0]     stat_drops;

    lanes_mosi_dispatch #(.LAYER_COUNT(LC)) dut (
        .clk_core                  (clk_core),
        .clk_core_resn             (clk_core_resn),
        .host_s_axis_tdata         (host_s_axis_tdata),
        .host_s_axis_tvalid        (host_s_axis_tvalid),
        .host_s_axis_tready        (host_s_axis_tready),
        .lanes_mosi_m_axis_tdata   (lanes_mosi_m_axis_tdata),
        .lanes_mosi_m_axis_tvalid  (lanes_mosi_m_axis_tvalid),
        .lanes_mosi_m_axis_tlast   (lanes_mosi_m_axis_tlast),
        .lanes_mosi_m_axis_tready  (lane_ready),
        .config_lanes_disable_mosi (dis),
        .config_dispatch_flush     (config_dispatch_flush),
        .status_busy               (status_busy),
        .status_dest               (status_dest),
        .stat_packets              (stat_packets),
        .stat_drops                (stat_drops)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        int         lane;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t         rx_q[$];
    beat_t         exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic [LC-1:0] force_low = '0;
    bit            rnd_ready = 0;
    bit            rnd_gap = 0;
    logic [31:0]   m_pkts = '0;
    logic [15:0]   m_drops = '0;

    initial forever begin
        @(negedge clk_core);
        for (int i = 0; i < LC; i++)
            lane_ready[i] = force_low[i] ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    // Lane handshakes sampled just before the rising edge that completes them.
    initial forever begin
        @(negedge clk_core);
        #4;
        for (int i = 0; i < LC; i++)
            if (lanes_mosi_m_axis_tvalid[i] && lane_ready[i])
                rx_q.push_back('{lane: i, data: lanes_mosi_m_axis_tdata[i*8 +: 8], last: lanes_mosi_m_axis_tlast[i]});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end of test");
        $fatal(1, "watchdog");
    end

    // Packet-level model: which lanes get the payload, or whether it is dropped.
    task automatic model_pkt(input logic [7:0] dest, input logic [7:0] pl[$]);
        logic [LC-1:0] tgt;
        tgt = '0;
        for (int i = 0; i < LC; i++)
            if (int'(dest) == i + 1 && !dis[i]) tgt[i] = 1'b1;
`ifdef MOSI_BROADCAST_EN
        if (dest == 8'hFF) tgt = ~dis;
`endif
        if (tgt == '0) begin
            if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end else begin
            m_pkts = m_pkts + 32'd1;
            for (int i = 0; i < LC; i++)
                if (tgt[i])
                    foreach (pl[k]) exp_q.push_back('{lane: i, data: pl[k], last: (k == pl.size() - 1)});
        end
    endtask

    function automatic int stream_errs();
        int errs = 0;
        for (int l = 0; l < LC; l++) begin
            beat_t g[$];
            beat_t e[$];
            foreach (rx_q[k]) if (rx_q[k].lane == l) g.push_back(rx_q[k]);
            foreach (exp_q[k]) if (exp_q[k].lane == l) e.push_back(exp_q[k]);
            if (g.size() != e.size()) errs++;
            for (int k = 0; k < g.size() && k < e.size(); k++)
                if (g[k].data !== e[k].data || g[k].last !== e[k].last) errs++;
        end
        return errs;
    endfunction

    // Called and returns on a falling edge; leaves tvalid high after acceptance.
    task automatic send_byte(input logic [7:0] b);
        int budget = 0;
        bit done = 0;
        if (rnd_gap && $urandom_range(0, 3) == 0) begin
            host_s_axis_tvalid = 1'b0;
            @(negedge clk_core);
        end
        host_s_axis_tdata  = b;
        host_s_axis_tvalid = 1'b1;
        while (!done) begin
            #1;
            done = host_s_axis_tready;
            @(negedge clk_core);
            budget++;
            if (!done && budget > 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_byte timeout: byte %02h not accepted after %0d cycles, required acceptance", b, budget);
                host_s_axis_tvalid = 1'b0;
                done = 1;
            end
        end
    endtask

    task automatic send_pkt(input logic [7:0] dest, input logic [7:0] pl[$]);
        model_pkt(dest, pl);
        send_byte(dest);
        send_byte(8'(pl.size() - 1));
        foreach (pl[k]) send_byte(pl[k]);
        host_s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        host_s_axis_tvalid = 1'b0;
        repeat (n) @(negedge clk_core);
    endtask

    task automatic test_reset();
        int e;
        repeat (3) @(negedge clk_core);
        host_s_axis_tvalid = 1'b1;
        #1;
        n_checks++;
        if (host_s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_tready: got %b required 0", host_s_axis_tready);
        end
        n_checks++;
        if (lanes_mosi_m_axis_tvalid !== '0 || lanes_mosi_m_axis_tlast !== '0) begin
            n_fail++;
            $display("FAIL reset_lane_outputs: valid %b tlast %b required 000/000",
                     lanes_mosi_m_axis_tvalid, lanes_mosi_m_axis_tlast);
        end
        @(negedge clk_core);
        host_s_axis_tvalid = 1'b0;
        clk_core_resn = 1'b1;
        #1;
        e = (status_busy !== 1'b0) + (status_dest !== 8'h00) + (stat_packets !== 32'd0) + (stat_drops !== 16'd0);
        n_checks++;
        if (e != 0) begin
            n_fail++;
            $display("FAIL reset_status: busy %b dest %02h packets %0d drops %0d required 0/00/0/0",
                     status_busy, status_dest, stat_packets, stat_drops);
        end
        n_checks++;
        if (host_s_axis_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle_tready: got %b required 1", host_s_axis_tready);
        end
        @(negedge clk_core);
    endtask

    task automatic test_unicast();
        logic [7:0] pl[$];
        int e;
        pl = {8'hA1, 8'hA2, 8'hA3};
        send_pkt(8'h02, pl);
        idle(3);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL unicast_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_packets !== m_pkts) begin
            n_fail++;
            $display("FAIL unicast_packets: got %0d required %0d", stat_packets, m_pkts);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic [7:0] pl[$];
        int e;
        pl = {8'h5C};
        model_pkt(8'h01, pl);
        force_low = 3'b001;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 4; k++) begin
            host_s_axis_tdata  = 8'h5C;
            host_s_axis_tvalid = 1'b1;
            #1;
            n_checks++;
            if (host_s_axis_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_tready cycle %0d: got %b required 0", k, host_s_axis_tready);
            end
            n_checks++;
            if (lanes_mosi_m_axis_tvalid !== 3'b001 || lanes_mosi_m_axis_tlast !== 3'b001) begin
                n_fail++;
                $display("FAIL stall_valid cycle %0d: valid %b tlast %b required 001/001",
                         k, lanes_mosi_m_axis_tvalid, lanes_mosi_m_axis_tlast);
            end
            if (k == 3) force_low = '0;
            @(negedge clk_core);
        end
        send_byte(8'h5C);
        idle(3);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL stall_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_packets !== m_pkts) begin
            n_fail++;
            $display("FAIL stall_packets: got %0d required %0d", stat_packets, m_pkts);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_drop_bad_dest();
        logic [7:0] pl[$];
        int e;
        pl = {8'h10, 8'h20, 8'h30, 8'h40};
        send_pkt(8'h07, pl);
        pl = {8'hEE};
        send_pkt(8'h03, pl);
        pl = {8'h99};
        send_pkt(8'h00, pl);
        idle(3);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL drop_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_drops !== m_drops) begin
            n_fail++;
            $display("FAIL drop_count: got %0d required %0d", stat_drops, m_drops);
        end
        n_checks++;
        if (stat_packets !== m_pkts) begin
            n_fail++;
            $display("FAIL drop_packets: got %0d required %0d", stat_packets, m_pkts);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_max_len();
        logic [7:0] pl[$];
        int e;
        for (int k = 0; k < 256; k++) pl.push_back(8'($urandom_range(0, 255)));
        rnd_ready = 1;
        send_pkt(8'h01, pl);
        idle(3);
        rnd_ready = 0;
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL maxlen_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_packets !== m_pkts) begin
            n_fail++;
            $display("FAIL maxlen_packets: got %0d required %0d", stat_packets, m_pkts);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_flush();
        logic [7:0] b[5];
        logic [7:0] pl[$];
        int e;
        foreach (b[k]) b[k] = 8'($urandom_range(0, 255));
        send_byte(8'h01);
        send_byte(8'h04);
        send_byte(b[0]);
        send_byte(b[1]);
        exp_q.push_back('{lane: 0, data: b[0], last: 1'b0});
        exp_q.push_back('{lane: 0, data: b[1], last: 1'b0});
        host_s_axis_tdata     = b[2];
        config_dispatch_flush = 1'b1;
        #1;
        n_checks++;
        if (host_s_axis_tready !== 1'b0 || lanes_mosi_m_axis_tvalid !== '0) begin
            n_fail++;
            $display("FAIL flush_cycle: tready %b valid %b required 0/000", host_s_axis_tready, lanes_mosi_m_axis_tvalid);
        end
        @(negedge clk_core);
        config_dispatch_flush = 1'b0;
        host_s_axis_tvalid    = 1'b0;
        #1;
        n_checks++;
        if (status_busy !== 1'b0 || lanes_mosi_m_axis_tvalid !== '0) begin
            n_fail++;
            $display("FAIL flush_after: busy %b valid %b required 0/000", status_busy, lanes_mosi_m_axis_tvalid);
        end
        @(negedge clk_core);
        pl = {8'h5A, 8'hC3};
        send_pkt(8'h03, pl);
        idle(3);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL flush_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_packets !== m_pkts || stat_drops !== m_drops) begin
            n_fail++;
            $display("FAIL flush_counters: packets %0d drops %0d required %0d/%0d", stat_packets, stat_drops, m_pkts, m_drops);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_disable();
        logic [7:0] pl[$];
        int e;
        pl = {8'h31, 8'h32, 8'h33};
        model_pkt(8'h03, pl);
        send_byte(8'h03);
        send_byte(8'h02);
        dis = 3'b100;
        foreach (pl[k]) send_byte(pl[k]);
        host_s_axis_tvalid = 1'b0;
        dis = 3'b010;
        pl = {8'h77};
        send_pkt(8'h02, pl);
        dis = 3'b000;
        idle(3);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL disable_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_packets !== m_pkts || stat_drops !== m_drops) begin
            n_fail++;
            $display("FAIL disable_counters: packets %0d drops %0d required %0d/%0d", stat_packets, stat_drops, m_pkts, m_drops);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_dest_ff();
        logic [7:0] pl[$];
        int e;
        pl = {8'h11, 8'h22};
        force_low = 3'b010;
        fork
            send_pkt(8'hFF, pl);
            begin
                repeat (5) @(negedge clk_core);
                #2 force_low = '0;
            end
        join
        idle(3);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL dest_ff_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_packets !== m_pkts || stat_drops !== m_drops) begin
            n_fail++;
            $display("FAIL dest_ff_counters: packets %0d drops %0d required %0d/%0d", stat_packets, stat_drops, m_pkts, m_drops);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_midpacket();
        logic [7:0] pl[$];
        int e;
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'hC0);
        exp_q.push_back('{lane: 1, data: 8'hC0, last: 1'b0});
        clk_core_resn = 1'b0;
        #1;
        n_checks++;
        if (host_s_axis_tready !== 1'b0 || lanes_mosi_m_axis_tvalid !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: tready %b valid %b required 0/000", host_s_axis_tready, lanes_mosi_m_axis_tvalid);
        end
        @(negedge clk_core);
        clk_core_resn      = 1'b1;
        host_s_axis_tvalid = 1'b0;
        m_pkts  = '0;
        m_drops = '0;
        #1;
        n_checks++;
        if (stat_packets !== 32'd0 || stat_drops !== 16'd0 || status_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_status: packets %0d drops %0d busy %b required 0/0/0", stat_packets, stat_drops, status_busy);
        end
        @(negedge clk_core);
        pl = {8'hD4};
        send_pkt(8'h01, pl);
        idle(3);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL midreset_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] pl[$];
        logic [7:0] dest;
        int e;
        int pick;
        rnd_ready = 1;
        rnd_gap   = 1;
        for (int p = 0; p < 40; p++) begin
            dis  = ($urandom_range(0, 2) == 0) ? LC'($urandom_range(0, 7)) : '0;
            pick = $urandom_range(0, 9);
            case (pick)
                0:       dest = 8'h00;
                1:       dest = 8'h04;
                2:       dest = 8'hFF;
                3:       dest = 8'($urandom_range(5, 254));
                default: dest = 8'($urandom_range(1, 3));
            endcase
            pl.delete();
            for (int k = 0; k < $urandom_range(1, 6); k++) pl.push_back(8'($urandom_range(0, 255)));
            send_pkt(dest, pl);
        end
        dis       = '0;
        rnd_ready = 0;
        rnd_gap   = 0;
        idle(4);
        n_checks++;
        e = stream_errs();
        if (e !== 0) begin
            n_fail++;
            $display("FAIL random_stream: %0d beat errors, got %0d beats expected %0d", e, rx_q.size(), exp_q.size());
        end
        n_checks++;
        if (stat_packets !== m_pkts) begin
            n_fail++;
            $display("FAIL random_packets: got %0d required %0d", stat_packets, m_pkts);
        end
        n_checks++;
        if (stat_drops !== m_drops) begin
            n_fail++;
            $display("FAIL random_drops: got %0d required %0d", stat_drops, m_drops);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_stall();
        test_drop_bad_dest();
        test_max_len();
        test_flush();
        test_disable();
        test_dest_ff();
        test_reset_midpacket();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
